// File: rtl/stream_peak_meter.sv
// Stereo AXI4-Stream peak meter: skid-buffered pass-through plus per-channel window peaks and clip count.
// Optional `PEAK_METER_TLAST_SYNC_EN`: an accepted tlast beat also closes the current peak window.
module stream_peak_meter #(
    parameter int unsigned WINDOW_LEN  = 4800,
    parameter logic [14:0] CLIP_THRESH = 15'h7FF0
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [14:0] peak_left,
    output logic [14:0] peak_right,
    output logic        peak_valid,
    output logic [15:0] clip_count,
    input  logic        clear_clip
);
    localparam logic [15:0] WCNT_LAST = 16'(WINDOW_LEN - 1);

    logic        sk_valid;
    logic        sk_last;
    logic [31:0] sk_data;
    logic [15:0] wcnt;
    logic [14:0] run_l, run_r;
    logic [14:0] mag_l, mag_r, max_l, max_r;
    logic        accept, emit, clipped, close_win;

    assign s_axis_tready = !sk_valid;
    assign accept        = s_axis_tvalid && !sk_valid;
    assign emit          = m_axis_tvalid && m_axis_tready;

    assign mag_l   = s_axis_tdata[14:0];
    assign mag_r   = s_axis_tdata[30:16];
    assign max_l   = (mag_l > run_l) ? mag_l : run_l;
    assign max_r   = (mag_r > run_r) ? mag_r : run_r;
    assign clipped = accept && ((mag_l >= CLIP_THRESH) || (mag_r >= CLIP_THRESH));

`ifdef PEAK_METER_TLAST_SYNC_EN
    assign close_win = (wcnt == WCNT_LAST) || s_axis_tlast;
`else
    assign close_win = (wcnt == WCNT_LAST);
`endif

    // Skid buffer: SK only fills when OR is held, so tready never depends on m_axis_tready.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            sk_valid      <= 1'b0;
            sk_data       <= '0;
            sk_last       <= 1'b0;
        end else if (emit && sk_valid) begin
            m_axis_tdata <= sk_data;
            m_axis_tlast <= sk_last;
            sk_valid     <= 1'b0;
        end else if (accept && (!m_axis_tvalid || emit)) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tvalid <= 1'b1;
        end else if (accept) begin
            sk_data  <= s_axis_tdata;
            sk_last  <= s_axis_tlast;
            sk_valid <= 1'b1;
        end else if (emit) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wcnt       <= '0;
            run_l      <= '0;
            run_r      <= '0;
            peak_left  <= '0;
            peak_right <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            if (accept) begin
                if (close_win) begin
                    peak_left  <= max_l;
                    peak_right <= max_r;
                    peak_valid <= 1'b1;
                    run_l      <= '0;
                    run_r      <= '0;
                    wcnt       <= '0;
                end else begin
                    run_l <= max_l;
                    run_r <= max_r;
                    wcnt  <= wcnt + 16'd1;
                end
            end
        end
    end

    // A clip coinciding with clear_clip survives as a count of one.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            clip_count <= '0;
        end else if (clear_clip) begin
            clip_count <= clipped ? 16'd1 : 16'd0;
        end else if (clipped && (clip_count != '1)) begin
            clip_count <= clip_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_stream_peak_meter.sv
// Self-checking bench for stream_peak_meter: queue/array reference model checked every cycle plus literal checks.
module tb_stream_peak_meter;
    localparam int unsigned WL = 4;
`ifdef PEAK_METER_TLAST_SYNC_EN
    localparam bit TSYNC = 1'b1;
`else
    localparam bit TSYNC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic [14:0] peak_left, peak_right;
    logic        peak_valid;
    logic [15:0] clip_count;
    logic        clear_clip = 1'b0;

    always #5 clk = ~clk;

    stream_peak_meter #(.WINDOW_LEN(WL), .CLIP_THRESH(15'h7FF0)) dut (
        .s_axi_aclk(clk),
        .s_axi_aresetn(rstn),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .peak_left(peak_left),
        .peak_right(peak_right),
        .peak_valid(peak_valid),
        .clip_count(clip_count),
        .clear_clip(clear_clip)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of beats in flight, current window's magnitudes, clip total.
    logic [32:0]  q[$];
    logic [14:0]  wl[$], wr[$];
    logic [14:0]  e_pl = '0, e_pr = '0;
    logic         e_pv = 1'b0;
    int unsigned  e_clip = 0;
    logic         m_acc, m_em, m_hit;
    logic [14:0]  ml, mr, mxl, mxr;

    always @(negedge clk) begin
        if (!rstn) begin
            q.delete(); wl.delete(); wr.delete();
            e_pl = '0; e_pr = '0; e_pv = 1'b0; e_clip = 0;
            chk("rst_tready", s_axis_tready, 1);
            chk("rst_mvalid", m_axis_tvalid, 0);
            chk("rst_mlast", m_axis_tlast, 0);
            chk("rst_mdata", m_axis_tdata, 0);
            chk("rst_pvalid", peak_valid, 0);
            chk("rst_peaks", {peak_left, peak_right}, 0);
            chk("rst_clip", clip_count, 0);
        end else begin
            chk("tready", s_axis_tready, q.size() < 2);
            chk("mvalid", m_axis_tvalid, q.size() > 0);
            if (q.size() > 0) begin
                chk("mdata", m_axis_tdata, q[0][31:0]);
                chk("mlast", m_axis_tlast, q[0][32]);
            end
            chk("peak_valid", peak_valid, e_pv);
            chk("peak_left", peak_left, e_pl);
            chk("peak_right", peak_right, e_pr);
            chk("clip_count", clip_count, 64'(e_clip));

            m_acc = s_axis_tvalid && (q.size() < 2);
            m_em  = (q.size() > 0) && m_axis_tready;
            ml = s_axis_tdata[14:0];
            mr = s_axis_tdata[30:16];
            if (m_em) void'(q.pop_front());
            if (m_acc) q.push_back({s_axis_tlast, s_axis_tdata});

            e_pv = 1'b0;
            if (m_acc) begin
                wl.push_back(ml);
                wr.push_back(mr);
                if (wl.size() == WL || (TSYNC && s_axis_tlast)) begin
                    mxl = '0; mxr = '0;
                    foreach (wl[k]) if (wl[k] > mxl) mxl = wl[k];
                    foreach (wr[k]) if (wr[k] > mxr) mxr = wr[k];
                    e_pl = mxl; e_pr = mxr; e_pv = 1'b1;
                    wl.delete(); wr.delete();
                end
            end

            m_hit = m_acc && (ml >= 15'h7FF0 || mr >= 15'h7FF0);
            if (clear_clip) e_clip = m_hit ? 1 : 0;
            else if (m_hit && e_clip < 65535) e_clip++;
        end
    end

    logic last_acc = 1'b0;

    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic mrdy, input logic clr);
        s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l;
        m_axis_tready = mrdy; clear_clip = clr;
        last_acc = v && s_axis_tready;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        s_axis_tvalid = 1'b0; clear_clip = 1'b0;
        #2;
        chk("lit_rst_tready", s_axis_tready, 1);
        chk("lit_rst_mvalid", m_axis_tvalid, 0);
        chk("lit_rst_peaks", {peak_left, peak_right}, 0);
        chk("lit_rst_pvalid", peak_valid, 0);
        chk("lit_rst_clip", clip_count, 0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    function automatic logic [14:0] rand_mag();
        case ($urandom_range(0, 3))
            0: rand_mag = 15'($urandom);
            1: rand_mag = 15'h7FE8 + 15'($urandom_range(0, 23));
            2: rand_mag = 15'($urandom_range(0, 255));
            default: rand_mag = 15'($urandom_range(0, 15'h7FEF));
        endcase
    endfunction

    logic [31:0] d;
    logic [31:0] seq_word;
    logic        v, l;

    initial begin
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;

        // Four-beat window from the reference stream.
        step(1'b1, 32'h0010_8020, 1'b0, 1'b1, 1'b0);
        chk("lit_lat1", m_axis_tdata, 32'h0010_8020);
        chk("lit_lat1_v", m_axis_tvalid, 1);
        step(1'b1, 32'h8100_0005, 1'b0, 1'b1, 1'b0);
        chk("lit_lat2", m_axis_tdata, 32'h8100_0005);
        step(1'b1, 32'h0003_7FFF, 1'b0, 1'b1, 1'b0);
        chk("lit_pv_early", peak_valid, 0);
        step(1'b1, 32'h0002_0001, 1'b0, 1'b1, 1'b0);
        chk("lit_pv", peak_valid, 1);
        chk("lit_pl", peak_left, 15'h7FFF);
        chk("lit_pr", peak_right, 15'h0100);
        chk("lit_clip1", clip_count, 1);
        idle(1);
        chk("lit_pv_off", peak_valid, 0);
        chk("lit_pl_hold", peak_left, 15'h7FFF);
        idle(2);

        // Backpressure: downstream stalled for 5 cycles with continuous input.
        seq_word = 32'h0000_0100;
        step(1'b1, 32'h0000_00A0, 1'b0, 1'b0, 1'b0);
        chk("lit_bp_rdy1", s_axis_tready, 1);
        step(1'b1, 32'h0000_00B0, 1'b1, 1'b0, 1'b0);
        chk("lit_bp_rdy2", s_axis_tready, 0);
        for (int i = 0; i < 3; i++) step(1'b1, seq_word, 1'b0, 1'b0, 1'b0);
        chk("lit_bp_hold", m_axis_tdata, 32'h0000_00A0);
        chk("lit_bp_rdy5", s_axis_tready, 0);
        for (int i = 0; i < 8; i++) begin
            if (last_acc) seq_word = seq_word + 1;
            step(1'b1, seq_word, 1'b0, 1'b1, 1'b0);
        end
        idle(3);

        // Clip saturation.
        for (int i = 0; i < 70000; i++) step(1'b1, 32'h7FFF_0000, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("lit_clip_sat", clip_count, 16'hFFFF);

        // clear_clip interactions and threshold boundary.
        step(1'b1, 32'h7FFF_0000, 1'b0, 1'b1, 1'b1);
        chk("lit_clr_hit", clip_count, 1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("lit_clr", clip_count, 0);
        step(1'b1, 32'h0000_7FEF, 1'b0, 1'b1, 1'b0);
        chk("lit_below_th", clip_count, 0);
        step(1'b1, 32'h7FF0_0000, 1'b0, 1'b1, 1'b0);
        chk("lit_at_th", clip_count, 1);
        idle(2);

        // Reset mid-window discards the partial window.
        pulse_reset();
        step(1'b1, 32'h7000_7000, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h7000_7000, 1'b0, 1'b1, 1'b0);
        pulse_reset();
        step(1'b1, 32'h0004_0011, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0022_0003, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0001_0030, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0005_0002, 1'b0, 1'b1, 1'b0);
        chk("lit_rw_pv", peak_valid, 1);
        chk("lit_rw_pl", peak_left, 15'h0030);
        chk("lit_rw_pr", peak_right, 15'h0022);
        idle(1);

`ifdef PEAK_METER_TLAST_SYNC_EN
        step(1'b1, 32'h0040_0009, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0007_0050, 1'b1, 1'b1, 1'b0);
        chk("lit_ts_pv", peak_valid, 1);
        chk("lit_ts_pl", peak_left, 15'h0050);
        chk("lit_ts_pr", peak_right, 15'h0040);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0001_0001, 1'b0, 1'b1, 1'b0);
        chk("lit_ts_pv3", peak_valid, 0);
        step(1'b1, 32'h0001_0001, 1'b0, 1'b1, 1'b0);
        chk("lit_ts_pv4", peak_valid, 1);
        idle(1);
`endif

        // Randomised traffic with random backpressure, checked by the model.
        v = 1'b0; d = '0; l = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!v || last_acc) begin
                v = ($urandom_range(0, 3) != 0);
                d = {1'($urandom), rand_mag(), 1'($urandom), rand_mag()};
                l = ($urandom_range(0, 7) == 0);
            end
            step(v, d, l, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
